// File: rtl/int_arb2.sv
// ---------------------------------------------------------------------------
// int_arb2 -- two-master arbiter for the internal register bus
//
// Shares one downstream int-bus slave between two int-bus masters. Each
// master may have one request outstanding; it is latched on the master's
// single-cycle strobe and held until the transaction completes. Grants
// alternate round-robin when both masters are waiting. Exactly one downstream
// transaction is in flight at a time. Its ack/err/rd_data is returned to the
// master that owns it. A transaction that is never acknowledged is ended
// with an error response after TIMEOUT cycles.
//
// Parameters:
//   ADDR_WIDTH  int-bus address width
//   DATA_WIDTH  int-bus data width (multiple of 8)
//   TIMEOUT     max cycles to wait for a downstream ack, 0 disables timeout
//
// Ports:
//   s_axi_aclk, s_axi_aresetn       clock, synchronous active-low reset
//   mN_addr/wr_data/wr_strb         master N request fields (N = 0, 1)
//   mN_wr_en / mN_rd_en             master N single-cycle request strobes
//   mN_wr_ack/wr_err                master N write response pulse / error
//   mN_rd_ack/rd_err/rd_data        master N read response pulse / error / data
//   int_addr/wr_data/wr_strb        downstream request fields (held)
//   int_wr_en / int_rd_en           downstream single-cycle strobes
//   int_wr_ack/wr_err               downstream write response
//   int_rd_ack/rd_err/rd_data       downstream read response
//   timeout_pulse                   one-cycle pulse when a transaction times out
// ---------------------------------------------------------------------------
module int_arb2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,

    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wr_data,
    input  logic [DATA_WIDTH/8-1:0] m0_wr_strb,
    input  logic                    m0_wr_en,
    input  logic                    m0_rd_en,
    output logic                    m0_wr_ack,
    output logic                    m0_wr_err,
    output logic                    m0_rd_ack,
    output logic                    m0_rd_err,
    output logic [DATA_WIDTH-1:0]   m0_rd_data,

    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wr_data,
    input  logic [DATA_WIDTH/8-1:0] m1_wr_strb,
    input  logic                    m1_wr_en,
    input  logic                    m1_rd_en,
    output logic                    m1_wr_ack,
    output logic                    m1_wr_err,
    output logic                    m1_rd_ack,
    output logic                    m1_rd_err,
    output logic [DATA_WIDTH-1:0]   m1_rd_data,

    output logic [ADDR_WIDTH-1:0]   int_addr,
    output logic [DATA_WIDTH-1:0]   int_wr_data,
    output logic [DATA_WIDTH/8-1:0] int_wr_strb,
    output logic                    int_wr_en,
    output logic                    int_rd_en,
    input  logic                    int_wr_ack,
    input  logic                    int_wr_err,
    input  logic                    int_rd_ack,
    input  logic                    int_rd_err,
    input  logic [DATA_WIDTH-1:0]   int_rd_data,

    output logic                    timeout_pulse
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                 state;
    logic [1:0]             pending;
    logic                   last_grant;
    logic                   owner;
    logic [CNT_WIDTH-1:0]   count;

    // Latched request per master: type (1 = write), address, data, strobes
    logic                   req_wr   [2];
    logic [ADDR_WIDTH-1:0]  req_addr [2];
    logic [DATA_WIDTH-1:0]  req_data [2];
    logic [STRB_WIDTH-1:0]  req_strb [2];

    logic [1:0]             capture;
    logic                   grant_valid;
    logic                   grant_sel;
    logic                   owner_wr;
    logic                   ack_hit;
    logic                   timed_out;
    logic                   resp_fire;
    logic                   resp_err;
    logic [DATA_WIDTH-1:0]  resp_data;
    logic [1:0]             pending_clr;

    // A strobe is taken only when that master has nothing outstanding.
    assign capture[0] = (m0_wr_en | m0_rd_en) & ~pending[0];
    assign capture[1] = (m1_wr_en | m1_rd_en) & ~pending[1];

    // Request latches. When wr_en and rd_en arrive together the request is
    // recorded as a write, so the read is simply dropped.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            for (int n = 0; n < 2; n++) begin
                req_wr[n]   <= 1'b0;
                req_addr[n] <= '0;
                req_data[n] <= '0;
                req_strb[n] <= '0;
            end
        end else begin
            if (capture[0]) begin
                req_wr[0]   <= m0_wr_en;
                req_addr[0] <= m0_addr;
                req_data[0] <= m0_wr_data;
                req_strb[0] <= m0_wr_strb;
            end
            if (capture[1]) begin
                req_wr[1]   <= m1_wr_en;
                req_addr[1] <= m1_addr;
                req_data[1] <= m1_wr_data;
                req_strb[1] <= m1_wr_strb;
            end
        end
    end

    // Round-robin choice: on a tie the master that did not win last time
    // is granted; otherwise whichever one is pending.
    always_comb begin
        grant_valid = |pending;
        if (pending == 2'b11) begin
            grant_sel = ~last_grant;
        end else begin
            grant_sel = pending[1];
        end
    end

    // Response decode for the transaction in flight. Only an ack of the
    // same type as the owner's request counts. A real ack in the limit
    // cycle wins over the timeout.
    always_comb begin
        owner_wr  = req_wr[owner];
        ack_hit   = owner_wr ? int_wr_ack : int_rd_ack;
        timed_out = (TIMEOUT != 0) && (count == CNT_LIMIT) && !ack_hit;
        resp_fire = (state == ST_WAIT) && (ack_hit || timed_out);
        if (timed_out) begin
            resp_err  = 1'b1;
            resp_data = '0;
        end else begin
            resp_err  = owner_wr ? int_wr_err : int_rd_err;
            resp_data = int_rd_data;
        end
        pending_clr = 2'b00;
        if (resp_fire) begin
            pending_clr[owner] = 1'b1;
        end
    end

    // Arbiter FSM. IDLE issues the next downstream strobe; WAIT counts
    // cycles from the strobe cycle and returns the response to the owner.
    // All strobes and response pulses default to 0 each cycle; the int_*
    // request fields and the rd_data outputs hold between transactions.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state         <= ST_IDLE;
            pending       <= 2'b00;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            count         <= '0;
            int_addr      <= '0;
            int_wr_data   <= '0;
            int_wr_strb   <= '0;
            int_wr_en     <= 1'b0;
            int_rd_en     <= 1'b0;
            m0_wr_ack     <= 1'b0;
            m0_wr_err     <= 1'b0;
            m0_rd_ack     <= 1'b0;
            m0_rd_err     <= 1'b0;
            m0_rd_data    <= '0;
            m1_wr_ack     <= 1'b0;
            m1_wr_err     <= 1'b0;
            m1_rd_ack     <= 1'b0;
            m1_rd_err     <= 1'b0;
            m1_rd_data    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            int_wr_en     <= 1'b0;
            int_rd_en     <= 1'b0;
            m0_wr_ack     <= 1'b0;
            m0_wr_err     <= 1'b0;
            m0_rd_ack     <= 1'b0;
            m0_rd_err     <= 1'b0;
            m1_wr_ack     <= 1'b0;
            m1_wr_err     <= 1'b0;
            m1_rd_ack     <= 1'b0;
            m1_rd_err     <= 1'b0;
            timeout_pulse <= 1'b0;

            pending <= (pending | capture) & ~pending_clr;

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        owner       <= grant_sel;
                        last_grant  <= grant_sel;
                        int_addr    <= req_addr[grant_sel];
                        int_wr_data <= req_data[grant_sel];
                        int_wr_strb <= req_strb[grant_sel];
                        int_wr_en   <= req_wr[grant_sel];
                        int_rd_en   <= ~req_wr[grant_sel];
                        count       <= '0;
                        state       <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (resp_fire) begin
                        timeout_pulse <= timed_out;
                        if (owner == 1'b0) begin
                            if (owner_wr) begin
                                m0_wr_ack <= 1'b1;
                                m0_wr_err <= resp_err;
                            end else begin
                                m0_rd_ack  <= 1'b1;
                                m0_rd_err  <= resp_err;
                                m0_rd_data <= resp_data;
                            end
                        end else begin
                            if (owner_wr) begin
                                m1_wr_ack <= 1'b1;
                                m1_wr_err <= resp_err;
                            end else begin
                                m1_rd_ack  <= 1'b1;
                                m1_rd_err  <= resp_err;
                                m1_rd_data <= resp_data;
                            end
                        end
                        state <= ST_IDLE;
                    end else begin
                        count <= count + CNT_WIDTH'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/int_arb2.md
Name: int_arb2

Overview:
Two-master arbiter for the internal register bus: shares one downstream int-bus slave between two int-bus masters (e.g. the AXI4-Lite bridge and a local configuration sequencer). Latches one outstanding request per master and grants round-robin. Drives exactly one downstream transaction at a time, routes the ack/err/rd_data back to the owner, and terminates hung transactions with a timeout error.

Parameters:
ADDR_WIDTH, 10, int-bus address width
DATA_WIDTH, 32, int-bus data width (multiple of 8)
TIMEOUT, 256, max cycles to wait for downstream ack; 0 disables timeout

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset
mN_addr (N=0,1)  in  ADDR_WIDTH  master N address, valid with strobe
mN_wr_data  in  DATA_WIDTH  master N write data
mN_wr_strb  in  DATA_WIDTH/8  master N byte strobes
mN_wr_en  in  1  master N write strobe, single cycle
mN_rd_en  in  1  master N read strobe, single cycle
mN_wr_ack / mN_wr_err  out  1 / 1  write response pulse / error qualifier
mN_rd_ack / mN_rd_err  out  1 / 1  read response pulse / error qualifier
mN_rd_data  out  DATA_WIDTH  read data, valid with mN_rd_ack
int_addr, int_wr_data, int_wr_strb  out  ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8  downstream request fields
int_wr_en / int_rd_en  out  1 / 1  downstream strobes, single cycle
int_wr_ack, int_wr_err, int_rd_ack, int_rd_err  in  1 each  downstream response; err qualified by ack
int_rd_data  in  DATA_WIDTH  downstream read data, valid with int_rd_ack
timeout_pulse  out  1  one-cycle pulse when a transaction times out

Behaviour:
- One clock; reset is synchronous and active-low (s_axi_aresetn sampled on s_axi_aclk rising edge).
- Reset: all outputs 0, pending flags cleared, FSM = IDLE, last_grant = 1 (so m0 wins the first tie), timeout counter 0.
- Capture: on mN_wr_en or mN_rd_en with no request pending for N, latch type/addr/data/strb and set pending[N]. A strobe while pending[N] is set is ignored. If wr_en and rd_en are both high, the write is latched and the read is discarded.
- FSM IDLE: if any pending, grant. When both are pending, grant the master != last_grant. Register int_addr/data/strb and assert int_wr_en or int_rd_en for exactly one cycle, then go to WAIT. Set last_grant on each grant.
- Latency: an upstream strobe in cycle T into an idle arbiter gives a downstream strobe in cycle T+2.
- FSM WAIT: the counter runs from 0 in the strobe cycle. A downstream ack of the matching type is accepted from the strobe cycle onward; an ack of the wrong type is ignored.
  - On ack in cycle R: in cycle R+1 pulse the owner's mN_*_ack for one cycle, with mN_*_err = int_*_err and, for reads, mN_rd_data = int_rd_data (held until the next read response). Clear pending[owner] and return to IDLE. The next grant's strobe comes no earlier than R+2.
- Timeout: if TIMEOUT != 0 and no ack has arrived when the counter reaches TIMEOUT, respond to the owner in the next cycle with ack=1, err=1, rd_data=0, and pulse timeout_pulse. This means the response comes TIMEOUT+1 cycles after the strobe cycle. A late downstream ack arriving in IDLE is ignored.
- Outside their single-cycle pulses, the downstream strobes and upstream acks are 0. The int_* request fields hold their last values.
- Reset mid-transaction: outputs immediately return to reset values in the next cycle and the in-flight request is dropped with no response.

Test Plan:
- m0 write addr 0x010, data 0xDEADBEEF, strb 0xF, slave acks 3 cycles after int_wr_en -> int_wr_en is one cycle at T+2 with those fields; m0_wr_ack pulses one cycle after the ack with m0_wr_err=0; m1 outputs stay 0.
- Four rounds of simultaneous m0 write + m1 read strobes, slave acking immediately -> downstream order m0,m1,m0,m1,m0,m1,m0,m1; there is never more than one strobe between acks.
- m1 read addr 0x3FC, slave acks with int_rd_err=1 and int_rd_data=0x00001234 -> m1_rd_ack=1, m1_rd_err=1, m1_rd_data=0x00001234; m0 outputs stay 0.
- TIMEOUT=16, m0 write, slave silent -> m0_wr_ack=1 and m0_wr_err=1 exactly 17 cycles after the int_wr_en cycle, with timeout_pulse in the same cycle; a slave ack 5 cycles later produces no upstream response.
- m0 asserts wr_en and rd_en together (addr 0x020) -> only int_wr_en is issued; only m0_wr_ack is returned.
- Reset asserted during WAIT of an m1 read -> all outputs 0 the next cycle, no m1_rd_ack; after release a fresh m0 write completes normally, and m0 wins a tie with m1.
